// File: rtl/pipelined_add_sub_pkg.sv
// Shared helpers for the pipelined add/subtract unit: width derivation and carry-in encoding.
package pipelined_add_sub_pkg;

    localparam int unsigned DefaultWidth  = 8;
    localparam int unsigned DefaultStages = 2;

    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    // Subtraction is A + ~B + ~borrow, so the borrow-in is inverted on the way in.
    function automatic logic eff_carry_in(input logic cin, input logic sub);
        return cin ^ sub;
    endfunction

endpackage

// File: rtl/pipelined_add_sub_add_slice.sv
// Combinational W-bit ripple-carry adder slice built from full-adder cells.
module add_slice
    import pipelined_add_sub_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [W:0] w_c;

    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]     = x[i] ^ y[i] ^ w_c[i];
            w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
        end
    end

    assign co       = w_c[W];
    assign c_msb_in = w_c[W-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined add/subtract: one CHUNK-bit ripple slice per stage, carry registered between stages,
// global stall on output back-pressure.
module pipelined_add_sub
    import pipelined_add_sub_pkg::*;
#(
    parameter int unsigned WIDTH  = DefaultWidth,
    parameter int unsigned STAGES = DefaultStages
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_add_sub: WIDTH (%0d) must be divisible by STAGES (%0d), 1..WIDTH",
               WIDTH, STAGES);
    end

    logic w_stall;

    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             r_valid;
        logic [WIDTH-1:0] r_sum;
        logic             r_c;

        logic             w_valid_in;
        logic [WIDTH-1:0] w_a_in;
        logic [WIDTH-1:0] w_b_in;
        logic [WIDTH-1:0] w_sum_in;
        logic [WIDTH-1:0] w_sum_next;
        logic             w_c_in;
        logic [CHUNK-1:0] w_s;
        logic             w_co;
        logic             w_c_msb;

        if (k == 0) begin : g_head
            assign w_valid_in = in_valid;
            assign w_a_in     = a;
            assign w_b_in     = sub ? ~b : b;
            assign w_c_in     = eff_carry_in(cin, sub);
            assign w_sum_in   = '0;
        end else begin : g_body
            assign w_valid_in = g_stage[k-1].r_valid;
            assign w_a_in     = g_stage[k-1].g_ops.r_a;
            assign w_b_in     = g_stage[k-1].g_ops.r_b;
            assign w_c_in     = g_stage[k-1].r_c;
            assign w_sum_in   = g_stage[k-1].r_sum;
        end

        add_slice #(
            .W(CHUNK)
        ) u_add_slice (
            .x       (w_a_in[k*CHUNK +: CHUNK]),
            .y       (w_b_in[k*CHUNK +: CHUNK]),
            .ci      (w_c_in),
            .s       (w_s),
            .co      (w_co),
            .c_msb_in(w_c_msb)
        );

        // Sum bits already produced upstream ride along; this stage fills in its own chunk.
        always_comb begin
            w_sum_next                    = w_sum_in;
            w_sum_next[k*CHUNK +: CHUNK]  = w_s;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_sum   <= '0;
                r_c     <= 1'b0;
            end else if (!w_stall) begin
                r_valid <= w_valid_in;
                r_sum   <= w_sum_next;
                r_c     <= w_co;
            end
        end

        if (k < STAGES - 1) begin : g_ops
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic             w_unused_msb;

            assign w_unused_msb = w_c_msb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (!w_stall) begin
                    r_a <= w_a_in;
                    r_b <= w_b_in;
                end
            end
        end else begin : g_tail
            logic r_ovf;
            logic w_unused_ops;

            // Only the last chunk's operand bits are consumed here.
            assign w_unused_ops = ^{w_a_in, w_b_in};

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (!w_stall) begin
                    r_ovf <= w_co ^ w_c_msb;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_valid;
    assign sum       = g_stage[STAGES-1].r_sum;
    assign cout      = g_stage[STAGES-1].r_c;
    assign ovf       = g_stage[STAGES-1].g_tail.r_ovf;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: four instances (STAGES 2,1,4,8) checked against an arithmetic
// model with a per-instance scoreboard that also tracks latency across stalls.
module tb_pipelined_add_sub;

    typedef struct {
        logic [9:0] r;
        int         c;
        int         s;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;

    logic       in_valid  [4];
    logic       out_ready [4];
    logic       in_ready  [4];
    logic       dut_ov    [4];
    logic       dut_cout  [4];
    logic       dut_ovf   [4];
    logic [7:0] dut_sum   [4];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    exp_t exp_q [4][$];
    int   cyc = 0;
    int   stall_cnt [4];
    int   pop_cnt   [4];

    always #5 clk = ~clk;

    pipelined_add_sub #(.WIDTH(8), .STAGES(2)) u_dut_s2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(dut_ov[0]), .out_ready(out_ready[0]),
        .sum(dut_sum[0]), .cout(dut_cout[0]), .ovf(dut_ovf[0])
    );
    pipelined_add_sub #(.WIDTH(8), .STAGES(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(dut_ov[1]), .out_ready(out_ready[1]),
        .sum(dut_sum[1]), .cout(dut_cout[1]), .ovf(dut_ovf[1])
    );
    pipelined_add_sub #(.WIDTH(8), .STAGES(4)) u_dut_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(dut_ov[2]), .out_ready(out_ready[2]),
        .sum(dut_sum[2]), .cout(dut_cout[2]), .ovf(dut_ovf[2])
    );
    pipelined_add_sub #(.WIDTH(8), .STAGES(8)) u_dut_s8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(dut_ov[3]), .out_ready(out_ready[3]),
        .sum(dut_sum[3]), .cout(dut_cout[3]), .ovf(dut_ovf[3])
    );

    function automatic int stg_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            default: return 8;
        endcase
    endfunction

    // Plain integer arithmetic: {sum, cout, ovf}.
    function automatic logic [9:0] model(input logic [7:0] ta, input logic [7:0] tb,
                                         input logic tc, input logic ts);
        int ua = int'(ta);
        int ub = int'(tb);
        int sa = int'($signed(ta));
        int sb = int'($signed(tb));
        int ic = tc ? 1 : 0;
        int r;
        int sr;
        logic c;
        logic o;
        if (!ts) begin
            r  = ua + ub + ic;
            sr = sa + sb + ic;
            c  = (r > 255);
        end else begin
            r  = ua - ub - ic;
            sr = sa - sb - ic;
            c  = (ua >= ub + ic);
        end
        o = (sr > 127) || (sr < -128);
        return {r[7:0], c, o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                         input logic ts);
        a   = ta;
        b   = tb;
        cin = tc;
        sub = ts;
    endtask

    task automatic set_valid_all(input logic v);
        for (int d = 0; d < 4; d++) in_valid[d] = v;
    endtask

    // Scoreboard: each accepted beat must emerge in order after STAGES plus stalled cycles.
    always @(negedge clk) begin
        exp_t ent;
        cyc++;
        for (int d = 0; d < 4; d++) begin
            if (rst) begin
                exp_q[d].delete();
            end else begin
                if (dut_ov[d] && out_ready[d]) begin
                    if (exp_q[d].size() == 0) begin
                        check($sformatf("extra result d%0d", d), 32'(dut_ov[d]), 32'd0);
                    end else begin
                        ent = exp_q[d].pop_front();
                        pop_cnt[d]++;
                        check($sformatf("result d%0d", d),
                              32'({dut_sum[d], dut_cout[d], dut_ovf[d]}), 32'(ent.r));
                        check($sformatf("latency d%0d", d), 32'(cyc - ent.c),
                              32'(stg_of(d) + stall_cnt[d] - ent.s));
                    end
                end
                if (in_valid[d] && in_ready[d]) begin
                    ent.r = model(a, b, cin, sub);
                    ent.c = cyc;
                    ent.s = stall_cnt[d];
                    exp_q[d].push_back(ent);
                end
                if (d == 0) begin
                    check("in_ready rule", 32'(in_ready[0]), 32'(!(dut_ov[0] && !out_ready[0])));
                end
                if (dut_ov[d] && !out_ready[d]) stall_cnt[d]++;
            end
        end
    end

    task automatic probe(input string name, input logic [7:0] ta, input logic [7:0] tb,
                         input logic tc, input logic ts, input logic [9:0] exp);
        int         lat [4];
        logic [9:0] got [4];
        for (int d = 0; d < 4; d++) begin
            lat[d] = 0;
            got[d] = '0;
        end
        drive(ta, tb, tc, ts);
        set_valid_all(1'b1);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) set_valid_all(1'b0);
            for (int d = 0; d < 4; d++) begin
                if (lat[d] == 0 && dut_ov[d]) begin
                    lat[d] = k;
                    got[d] = {dut_sum[d], dut_cout[d], dut_ovf[d]};
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            check($sformatf("%s latency d%0d", name, d), 32'(lat[d]), 32'(stg_of(d)));
            check($sformatf("%s value d%0d", name, d), 32'(got[d]), 32'(exp));
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] held;
        int         p0;
        int         p_all [4];
        int         ov_seen [4];
        logic [7:0] av;
        logic [7:0] bv;
        logic       acc;
        int         cnt;

        for (int d = 0; d < 4; d++) begin
            stall_cnt[d] = 0;
            pop_cnt[d]   = 0;
            out_ready[d] = 1'b1;
        end
        set_valid_all(1'b0);
        rst = 1'b1;
        drive(8'h00, 8'h00, 1'b0, 1'b0);

        // Model pinned by hand-computed values.
        check("model FF+01", 32'(model(8'hFF, 8'h01, 1'b0, 1'b0)), 32'({8'h00, 1'b1, 1'b0}));
        check("model 7F+01", 32'(model(8'h7F, 8'h01, 1'b0, 1'b0)), 32'({8'h80, 1'b0, 1'b1}));
        check("model 80-01", 32'(model(8'h80, 8'h01, 1'b0, 1'b1)), 32'({8'h7F, 1'b1, 1'b1}));
        check("model 05-03", 32'(model(8'h05, 8'h03, 1'b0, 1'b1)), 32'({8'h02, 1'b1, 1'b0}));

        // Reset state.
        step();
        step();
        check("reset out_valid", 32'(dut_ov[0]), 32'd0);
        check("reset sum", 32'(dut_sum[0]), 32'd0);
        check("reset cout", 32'(dut_cout[0]), 32'd0);
        check("reset ovf", 32'(dut_ovf[0]), 32'd0);
        check("reset in_ready", 32'(in_ready[0]), 32'd1);
        rst = 1'b0;
        repeat (3) step();
        check("idle out_valid", 32'(dut_ov[0]), 32'd0);
        check("idle in_ready", 32'(in_ready[0]), 32'd1);

        // Directed single beats with literal results and per-instance latency.
        probe("add FF+01", 8'hFF, 8'h01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0});
        probe("add 7F+01", 8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1});
        probe("sub 80-01", 8'h80, 8'h01, 1'b0, 1'b1, {8'h7F, 1'b1, 1'b1});
        probe("sub 00-01", 8'h00, 8'h01, 1'b0, 1'b1, {8'hFF, 1'b0, 1'b0});
        probe("sub 05-03", 8'h05, 8'h03, 1'b0, 1'b1, {8'h02, 1'b1, 1'b0});

        // 16 back-to-back beats.
        for (int d = 0; d < 4; d++) p_all[d] = pop_cnt[d];
        for (int i = 0; i < 16; i++) begin
            drive(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)),
                  1'($urandom_range(1)));
            set_valid_all(1'b1);
            step();
        end
        set_valid_all(1'b0);
        repeat (12) step();
        for (int d = 0; d < 4; d++) begin
            check($sformatf("stream count d%0d", d), 32'(pop_cnt[d] - p_all[d]), 32'd16);
        end

        // Back-pressure: fill the STAGES=2 pipe and hold it for 5 cycles.
        out_ready[0] = 1'b0;
        drive(8'h11, 8'h22, 1'b0, 1'b0);
        in_valid[0] = 1'b1;
        step();
        drive(8'h90, 8'h10, 1'b1, 1'b1);
        step();
        drive(8'h3C, 8'hC3, 1'b1, 1'b0);
        held = {dut_sum[0], dut_cout[0], dut_ovf[0]};
        p0   = pop_cnt[0];
        for (int i = 0; i < 5; i++) begin
            check("stall in_ready", 32'(in_ready[0]), 32'd0);
            check("stall out_valid", 32'(dut_ov[0]), 32'd1);
            check("stall hold", 32'({dut_sum[0], dut_cout[0], dut_ovf[0]}), 32'(held));
            step();
        end
        out_ready[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        repeat (6) step();
        check("stall drain count", 32'(pop_cnt[0] - p0), 32'd3);
        check("stall drain empty", 32'(exp_q[0].size()), 32'd0);

        // Reset with two beats in flight.
        drive(8'h44, 8'h55, 1'b0, 1'b0);
        set_valid_all(1'b1);
        step();
        drive(8'hA0, 8'h0F, 1'b1, 1'b1);
        step();
        set_valid_all(1'b0);
        out_ready[0] = 1'b0;
        rst = 1'b1;
        step();
        for (int d = 0; d < 4; d++) begin
            check($sformatf("mid-reset out_valid d%0d", d), 32'(dut_ov[d]), 32'd0);
        end
        check("mid-reset sum", 32'(dut_sum[0]), 32'd0);
        rst = 1'b0;
        out_ready[0] = 1'b1;
        for (int d = 0; d < 4; d++) ov_seen[d] = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            for (int d = 0; d < 4; d++) if (dut_ov[d]) ov_seen[d]++;
        end
        for (int d = 0; d < 4; d++) begin
            check($sformatf("post-reset ghosts d%0d", d), 32'(ov_seen[d]), 32'd0);
        end

        // Sweep all a with boundary/derived b, all cin/sub; random stalls and bubbles on d0.
        for (int i = 0; i < 256; i++) begin
            av = 8'(i);
            for (int bs = 0; bs < 8; bs++) begin
                case (bs)
                    0:       bv = 8'h00;
                    1:       bv = 8'h01;
                    2:       bv = 8'h7F;
                    3:       bv = 8'h80;
                    4:       bv = 8'hFF;
                    5:       bv = av ^ 8'h55;
                    6:       bv = ~av;
                    default: bv = 8'($urandom_range(255));
                endcase
                for (int cs = 0; cs < 4; cs++) begin
                    if ($urandom_range(7) == 0) begin
                        set_valid_all(1'b0);
                        step();
                    end
                    drive(av, bv, cs[0], cs[1]);
                    set_valid_all(1'b1);
                    cnt = 0;
                    do begin
                        out_ready[0] = ($urandom_range(3) != 0);
                        #1;
                        acc = in_ready[0];
                        @(posedge clk);
                        #1;
                        cnt++;
                    end while (!acc && cnt < 50);
                    if (!acc) check("sweep accept", 32'(acc), 32'd1);
                end
            end
        end

        set_valid_all(1'b0);
        for (int d = 0; d < 4; d++) out_ready[d] = 1'b1;
        repeat (20) step();
        for (int d = 0; d < 4; d++) begin
            check($sformatf("final drain d%0d", d), 32'(exp_q[d].size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
